auto_phase_ctrl: RTL

Per-approach vehicle signal head controller, directly downstream of the intersection sequencer FSM. It consumes that FSM's enable/clear/service commands and returns done. It drives one approach's red/yellow/green lamps through a timed green -> yellow -> all-red clearance cycle, and provides a service-mode flashing yellow. One instance is used per approach (sud, est, vest, nord), with a different SECUNDE_VERDE per instance.

---
 rtl/auto_phase_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/auto_phase_ctrl.sv
// rtl/auto_phase_ctrl.sv - per-approach signal head controller: green -> yellow -> all-red, plus service flash
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   enable    start strobe from the sequencer, only looked at in IDLE
//   clear     synchronous abort / acknowledge, returns to IDLE
//   service   service-mode request (debounced level), flashes yellow
//   done      high while the cycle is complete and awaiting clear
//   verde     green lamp
//   galben    yellow lamp
//   rosu      red lamp
//   sec_left  seconds remaining in the current timed state, 0 otherwise

module auto_phase_ctrl #(
  parameter int unsigned DIV_FACTOR_SEC     = 10000000,
  parameter int unsigned SECUNDE_VERDE      = 25,
  parameter int unsigned SECUNDE_GALBEN     = 3,
  parameter int unsigned SECUNDE_ROSU_CLEAR = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  input  logic       service,
  output logic       done,
  output logic       verde,
  output logic       galben,
  output logic       rosu,
  output logic [7:0] sec_left
);

  localparam int unsigned PW = (DIV_FACTOR_SEC > 2) ? $clog2(DIV_FACTOR_SEC) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV_FACTOR_SEC - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(DIV_FACTOR_SEC / 2 - 1);

  localparam logic [7:0] LOAD_VERDE  = 8'(SECUNDE_VERDE);
  localparam logic [7:0] LOAD_GALBEN = 8'(SECUNDE_GALBEN);
  localparam logic [7:0] LOAD_ROSU   = 8'(SECUNDE_ROSU_CLEAR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VERDE,
    S_GALBEN,
    S_ROSU_CLEAR,
    S_DONE,
    S_SERVICE
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic          blink;
  logic [3:0]    lamps_q;   // {done, verde, galben, rosu}
  logic          tick;

  assign tick = (prescaler == PRE_LAST);
  assign {done, verde, galben, rosu} = lamps_q;

  // Output image of a state; written together with the state register so the
  // lamps always match the state they belong to.
  function automatic logic [3:0] decode(input state_t s, input logic b);
    case (s)
      S_VERDE:   decode = 4'b0100;
      S_GALBEN:  decode = 4'b0010;
      S_DONE:    decode = 4'b1001;
      S_SERVICE: decode = {2'b00, b, 1'b0};
      default:   decode = 4'b0001;
    endcase
  endfunction

  function automatic state_t next_timed(input state_t s);
    case (s)
      S_VERDE:  next_timed = S_GALBEN;
      S_GALBEN: next_timed = S_ROSU_CLEAR;
      default:  next_timed = S_DONE;
    endcase
  endfunction

  function automatic logic [7:0] load_of(input state_t s);
    case (s)
      S_VERDE:  load_of = LOAD_GALBEN;
      S_GALBEN: load_of = LOAD_ROSU;
      default:  load_of = 8'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      prescaler <= '0;
      sec_left  <= 8'd0;
      blink     <= 1'b0;
      lamps_q   <= 4'b0001;
    end else if (clear) begin
      state     <= S_IDLE;
      prescaler <= '0;
      sec_left  <= 8'd0;
      blink     <= 1'b0;
      lamps_q   <= decode(S_IDLE, 1'b0);
    end else if (service) begin
      if (state != S_SERVICE) begin
        state     <= S_SERVICE;
        prescaler <= '0;
        sec_left  <= 8'd0;
        blink     <= 1'b1;
        lamps_q   <= decode(S_SERVICE, 1'b1);
      end else begin
        prescaler <= tick ? '0 : prescaler + PW'(1);
        // Two toggles per prescaler period give a 50% duty 1 Hz flash.
        if (tick || prescaler == PRE_HALF) begin
          blink   <= ~blink;
          lamps_q <= decode(S_SERVICE, ~blink);
        end
      end
    end else begin
      case (state)
        S_IDLE: begin
          prescaler <= '0;
          blink     <= 1'b0;
          if (enable) begin
            state    <= S_VERDE;
            sec_left <= LOAD_VERDE;
            lamps_q  <= decode(S_VERDE, 1'b0);
          end
        end
        S_VERDE, S_GALBEN, S_ROSU_CLEAR: begin
          if (tick) begin
            prescaler <= '0;
            if (sec_left == 8'd1) begin
              state    <= next_timed(state);
              sec_left <= load_of(state);
              lamps_q  <= decode(next_timed(state), 1'b0);
            end else begin
              sec_left <= sec_left - 8'd1;
            end
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end
        S_DONE: begin
          // Held until clear; enable has no effect here.
          prescaler <= '0;
        end
        S_SERVICE: begin
          // Service request dropped: park in IDLE with red on.
          state     <= S_IDLE;
          prescaler <= '0;
          sec_left  <= 8'd0;
          blink     <= 1'b0;
          lamps_q   <= decode(S_IDLE, 1'b0);
        end
        default: begin
          state     <= S_IDLE;
          prescaler <= '0;
          sec_left  <= 8'd0;
          blink     <= 1'b0;
          lamps_q   <= decode(S_IDLE, 1'b0);
        end
      endcase
    end
  end

endmodule
